// File: rtl/div_16x8_radix_2_seq_if.sv
// Operand/result bundle for the sequential radix-2 divider.
// The master drives operands and start; the slave returns results and status.
interface div_16x8_radix_2_seq_if #(
  parameter int unsigned N = 8
);
  logic           start;
  logic [2*N-1:0] dividend;
  logic [N-1:0]   divisor;
  logic [2*N-1:0] quotient;
  logic [N-1:0]   remainder;
  logic           busy;
  logic           done;
  logic           div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done, div_by_zero
  );
endinterface

// File: rtl/div_16x8_radix_2_seq.sv
// Sequential restoring radix-2 divider: 2N-bit dividend / N-bit divisor, one quotient bit per clock.
// Define DIV_SIGNED_EN for two's-complement operands (truncating toward zero).
module div_16x8_radix_2_seq #(
  parameter int unsigned N = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  div_16x8_radix_2_seq_if.slave bus
);

  localparam int unsigned QW = 2 * N;
  localparam int unsigned CW = $clog2(QW + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  logic [N-1:0]   rem;
  logic [QW-1:0]  shreg;
  logic [N-1:0]   dvsr;
  logic [CW-1:0]  cnt;

  logic [N:0]     rem_shift;
  logic [N:0]     rem_sub;
  logic           q_bit;
  logic [N:0]     rem_next;
  logic [QW-1:0]  sh_next;
  logic           last_step;
  logic [QW-1:0]  dd_abs;
  logic [N-1:0]   dv_abs;
  logic [QW-1:0]  q_res;
  logic [N-1:0]   r_res;

`ifdef DIV_SIGNED_EN
  logic           neg_q;
  logic           neg_r;
`endif

  // One restoring step: shift in the next dividend bit, trial-subtract at N+1 bits.
  always_comb begin
    rem_shift = {rem, shreg[QW-1]};
    rem_sub   = rem_shift - {1'b0, dvsr};
    q_bit     = (rem_shift >= {1'b0, dvsr});
    rem_next  = q_bit ? rem_sub : rem_shift;
    sh_next   = {shreg[QW-2:0], q_bit};
    last_step = (cnt == CW'(QW - 1));
  end

  // Operand conditioning on acceptance and result fix-up on completion.
  always_comb begin
`ifdef DIV_SIGNED_EN
    dd_abs = bus.dividend[QW-1] ? (~bus.dividend + QW'(1)) : bus.dividend;
    dv_abs = bus.divisor[N-1]   ? (~bus.divisor  + N'(1))  : bus.divisor;
    q_res  = neg_q ? (~sh_next + QW'(1)) : sh_next;
    r_res  = neg_r ? (~rem_next[N-1:0] + N'(1)) : rem_next[N-1:0];
`else
    dd_abs = bus.dividend;
    dv_abs = bus.divisor;
    q_res  = sh_next;
    r_res  = rem_next[N-1:0];
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      rem             <= '0;
      shreg           <= '0;
      dvsr            <= '0;
      cnt             <= '0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_q           <= 1'b0;
      neg_r           <= 1'b0;
`endif
    end else begin
      case (state)
        // DONE accepts a new start exactly like IDLE so operations can run back to back.
        IDLE, DONE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            shreg           <= dd_abs;
            dvsr            <= dv_abs;
            rem             <= '0;
            cnt             <= '0;
            bus.busy        <= 1'b1;
            bus.div_by_zero <= (bus.divisor == '0);
`ifdef DIV_SIGNED_EN
            neg_q           <= bus.dividend[QW-1] ^ bus.divisor[N-1];
            neg_r           <= bus.dividend[QW-1];
`endif
            state           <= CALC;
          end else begin
            bus.busy <= 1'b0;
            state    <= IDLE;
          end
        end

        CALC: begin
          rem   <= rem_next[N-1:0];
          shreg <= sh_next;
          cnt   <= cnt + CW'(1);
          if (last_step) begin
            bus.quotient  <= q_res;
            bus.remainder <= r_res;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b1;
            state         <= DONE;
          end
        end

        default: begin
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
